// File: rtl/freq_synth_gen.sv
// freq_synth_gen: programmable square-wave source used as the known-frequency
// stimulus for the frequency meter input. Output frequency is Clk/period with
// a programmable high time. New settings arrive on a valid/ready handshake and
// only take effect on a period boundary, so Fxout never glitches.
//
// Optional build macro BURST_COUNT_EN adds Burst_len/Burst_done: the block
// runs Burst_len periods (0 = continuous) and then returns to idle on its own.
module freq_synth_gen #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MIN_PERIOD = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Cfg_valid,
  output logic             Cfg_ready,
  input  logic [CNT_W-1:0] Cfg_period,
  input  logic [CNT_W-1:0] Cfg_high,
  input  logic             Enable,
  output logic             Fxout,
  output logic             Period_tick,
  output logic             Busy,
  output logic             Cfg_err
`ifdef BURST_COUNT_EN
  ,
  input  logic [CNT_W-1:0] Burst_len,
  output logic             Burst_done
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } cfg_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cfg_t             active_q, active_d;
  cfg_t             pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             fx_q, fx_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  cfg_t             cfg_in;
  logic             cfg_fire;
  logic             cfg_legal;
  logic             cfg_take;
  logic             at_boundary;
  logic             burst_fin;

`ifdef BURST_COUNT_EN
  logic [CNT_W-1:0] burst_len_q, burst_len_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             done_q, done_d;
`endif

  assign cfg_in.period = Cfg_period;
  assign cfg_in.high   = Cfg_high;

  // Handshake qualification and legality of the offered word
  assign cfg_fire  = Cfg_valid && ready_q;
  assign cfg_legal = (Cfg_period >= CNT_W'(MIN_PERIOD)) &&
                     (Cfg_high != '0) &&
                     (Cfg_high < Cfg_period);
  assign cfg_take  = cfg_fire && cfg_legal;

  // Last cycle of the current period; compare against period-1 to avoid overflow
  assign at_boundary = (state_q != ST_IDLE) &&
                       (cnt_q == (active_q.period - CNT_W'(1)));

`ifdef BURST_COUNT_EN
  // Final period of a finite burst; a lowered Enable takes precedence
  assign burst_fin = Enable && (burst_len_q != '0) &&
                     (burst_cnt_q == (burst_len_q - CNT_W'(1)));
`else
  assign burst_fin = 1'b0;
`endif

  // State, counter, config and output registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      active_q    <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      fx_q        <= 1'b0;
      tick_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      ready_q     <= 1'b1;
`ifdef BURST_COUNT_EN
      burst_len_q <= '0;
      burst_cnt_q <= '0;
      done_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      fx_q        <= fx_d;
      tick_q      <= tick_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
`ifdef BURST_COUNT_EN
      burst_len_q <= burst_len_d;
      burst_cnt_q <= burst_cnt_d;
      done_q      <= done_d;
`endif
    end
  end

  // Next-state, counter, config handling and registered-output next values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pend_d      = pend_q;
    pend_vld_d  = pend_vld_q;
    err_d       = cfg_fire && !cfg_legal;
`ifdef BURST_COUNT_EN
    burst_len_d = burst_len_q;
    burst_cnt_d = burst_cnt_q;
    done_d      = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // A word parked on the final boundary is drained here; otherwise load directly
        if (pend_vld_q) begin
          active_d   = pend_q;
          pend_vld_d = 1'b0;
        end else if (cfg_take) begin
          active_d = cfg_in;
        end
        // Start only once a configuration has been loaded
        if (Enable && (active_q.period != '0)) begin
          state_d = ST_RUN;
`ifdef BURST_COUNT_EN
          burst_len_d = Burst_len;
          burst_cnt_d = '0;
`endif
        end
      end

      default: begin
        if (at_boundary) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            active_d   = pend_q;
            pend_vld_d = 1'b0;
          end
          // Pending slot was empty, so a word taken now waits one more period
          if (cfg_take) begin
            pend_d     = cfg_in;
            pend_vld_d = 1'b1;
          end
          if (!Enable || burst_fin) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN;
          end
`ifdef BURST_COUNT_EN
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          done_d      = burst_fin;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cfg_take) begin
            pend_d     = cfg_in;
            pend_vld_d = 1'b1;
          end
          state_d = Enable ? ST_RUN : ST_STOPPING;
        end
      end
    endcase

    // Outputs follow the counter value of the coming cycle
    fx_d    = (state_d != ST_IDLE) && (cnt_d < active_d.high);
    tick_d  = (state_d != ST_IDLE) &&
              (cnt_d == (active_d.period - CNT_W'(1)));
    busy_d  = (state_d != ST_IDLE);
    ready_d = !pend_vld_d;
  end

  assign Fxout       = fx_q;
  assign Period_tick = tick_q;
  assign Busy        = busy_q;
  assign Cfg_err     = err_q;
  assign Cfg_ready   = ready_q;
`ifdef BURST_COUNT_EN
  assign Burst_done  = done_q;
`endif

endmodule
